// File: rtl/id_pkg.sv
// Shared decode constants for the MIPS ID stage: opcodes, functs,
// control-bundle bit positions and the RegDst / ALUOp encodings.
package id_pkg;

  localparam int unsigned ID_EX_CTRL_W = 13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_REG_DST    = 5;
  localparam int unsigned CTRL_LINK       = 7;
  localparam int unsigned CTRL_SHAMT_SRC  = 8;
  localparam int unsigned CTRL_ALU_OP     = 9;

  typedef enum logic [1:0] {
    REGDST_RT = 2'b00,
    REGDST_RD = 2'b01,
    REGDST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_op_e;

  // True when a producer destination names a real (non-$0) source register.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file: $0 hardwired to zero, two combinational read ports
// with write-through from the single clocked write port.
module register_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != 5'd0) rs_data = (we && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
    if (rt_addr != 5'd0) rt_data = (we && wr_addr == rt_addr) ? wr_data : regs[rt_addr];
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: decode, register read, branch/jump resolution,
// hazard detection and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [63:0]             IF_ID,
  input  logic [1:0]              status,
  input  logic                    wb_reg_write,
  input  logic [4:0]              wb_write_addr,
  input  logic [31:0]             wb_write_data,
  input  logic                    ex_reg_write,
  input  logic                    ex_mem_read,
  input  logic [4:0]              ex_write_addr,
  input  logic                    mem_reg_write,
  input  logic                    mem_mem_read,
  input  logic [4:0]              mem_write_addr,
  input  logic [31:0]             mem_alu_result,
  output logic                    PC_IF_ID_Write,
  output logic [2:0]              select_PC_next,
  output logic [31:0]             branch_target,
  output logic [31:0]             jump_target,
  output logic [31:0]             jr_target,
  output logic [ID_EX_CTRL_W-1:0] id_ex_ctrl,
  output logic [31:0]             id_ex_pc_plus4,
  output logic [31:0]             id_ex_rs_data,
  output logic [31:0]             id_ex_rt_data,
  output logic [31:0]             id_ex_imm,
  output logic [4:0]              id_ex_rs,
  output logic [4:0]              id_ex_rt,
  output logic [4:0]              id_ex_rd,
  output logic [4:0]              id_ex_shamt
);

  logic [31:0] pc4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign pc4    = IF_ID[63:32];
  assign instr  = IF_ID[31:0];
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  logic [31:0] rf_rs_data, rf_rt_data;

  register_file u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (rs),
    .rt_addr (rt),
    .rs_data (rf_rs_data),
    .rt_data (rf_rt_data),
    .we      (wb_reg_write),
    .wr_addr (wb_write_addr),
    .wr_data (wb_write_data)
  );

  logic [ID_EX_CTRL_W-1:0] ctrl;
  reg_dst_e reg_dst;
  alu_op_e  alu_op;
  logic r_valid, imm_zext, imm_lui, use_rs, use_rt;
  logic is_beq, is_bne, is_j, is_jr;

  always_comb begin
    ctrl     = '0;
    reg_dst  = REGDST_RT;
    alu_op   = ALU_ADD;
    r_valid  = 1'b0;
    imm_zext = 1'b0;
    imm_lui  = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jr    = 1'b0;
    // All-zero word is the flush/nop encoding, not "sll $0,$0,0".
    if (instr != '0) begin
      case (opcode)
        OP_RTYPE: begin
          r_valid = 1'b1;
          use_rs  = 1'b1;
          use_rt  = 1'b1;
          case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_ADDU: alu_op = ALU_ADDU;
            FN_SUB:  alu_op = ALU_SUB;
            FN_SUBU: alu_op = ALU_SUBU;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLTU: alu_op = ALU_SLTU;
            FN_SLL:  begin alu_op = ALU_SLL; use_rs = 1'b0; ctrl[CTRL_SHAMT_SRC] = 1'b1; end
            FN_SRL:  begin alu_op = ALU_SRL; use_rs = 1'b0; ctrl[CTRL_SHAMT_SRC] = 1'b1; end
            FN_SRA:  begin alu_op = ALU_SRA; use_rs = 1'b0; ctrl[CTRL_SHAMT_SRC] = 1'b1; end
            FN_JR:   begin r_valid = 1'b0; use_rt = 1'b0; is_jr = 1'b1; end
            FN_JALR: begin
              r_valid = 1'b0;
              use_rt  = 1'b0;
              is_jr   = 1'b1;
              ctrl[CTRL_REG_WRITE] = 1'b1;
              ctrl[CTRL_LINK]      = 1'b1;
              reg_dst = REGDST_RD;
            end
            default: begin r_valid = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
          endcase
          if (r_valid) begin
            ctrl[CTRL_REG_WRITE] = 1'b1;
            reg_dst = REGDST_RD;
          end
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
          ctrl[CTRL_REG_WRITE] = 1'b1;
          ctrl[CTRL_ALU_SRC]   = 1'b1;
          use_rs = (opcode != OP_LUI);
          case (opcode)
            OP_ADDIU: alu_op = ALU_ADDU;
            OP_SLTI:  alu_op = ALU_SLT;
            OP_SLTIU: alu_op = ALU_SLTU;
            OP_ANDI:  begin alu_op = ALU_AND; imm_zext = 1'b1; end
            OP_ORI:   begin alu_op = ALU_OR;  imm_zext = 1'b1; end
            OP_XORI:  begin alu_op = ALU_XOR; imm_zext = 1'b1; end
            OP_LUI:   begin alu_op = ALU_LUI; imm_lui  = 1'b1; end
            default:  alu_op = ALU_ADD;
          endcase
        end
        OP_LW: begin
          ctrl[CTRL_REG_WRITE]  = 1'b1;
          ctrl[CTRL_MEM_READ]   = 1'b1;
          ctrl[CTRL_MEM_TO_REG] = 1'b1;
          ctrl[CTRL_ALU_SRC]    = 1'b1;
          use_rs = 1'b1;
        end
        OP_SW: begin
          ctrl[CTRL_MEM_WRITE] = 1'b1;
          ctrl[CTRL_ALU_SRC]   = 1'b1;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_BEQ: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_BNE: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
        OP_J:   is_j = 1'b1;
        OP_JAL: begin
          is_j = 1'b1;
          ctrl[CTRL_REG_WRITE] = 1'b1;
          ctrl[CTRL_LINK]      = 1'b1;
          reg_dst = REGDST_RA;
        end
        default: ;
      endcase
    end
    ctrl[CTRL_REG_DST +: 2] = reg_dst;
    ctrl[CTRL_ALU_OP +: 4]  = alu_op;
  end

  logic [31:0] imm_ext;
  assign imm_ext = imm_lui  ? {imm, 16'h0000} :
                   imm_zext ? {16'h0000, imm} :
                              {{16{imm[15]}}, imm};

  // Branch/jr operands: only a non-load result sitting in MEM can be forwarded here.
  logic        mem_fwd_ok;
  logic [31:0] rs_fwd, rt_fwd;
  assign mem_fwd_ok = mem_reg_write && !mem_mem_read;
  assign rs_fwd = (mem_fwd_ok && reg_match(mem_write_addr, rs)) ? mem_alu_result : rf_rs_data;
  assign rt_fwd = (mem_fwd_ok && reg_match(mem_write_addr, rt)) ? mem_alu_result : rf_rt_data;

  logic [30:0] br_off;
  assign br_off        = {{13{imm[15]}}, imm, 2'b00};
  assign branch_target = {pc4[31], pc4[30:0] + br_off};
  assign jump_target   = {pc4[31:28], instr[25:0], 2'b00};
  assign jr_target     = rs_fwd;

  logic br_rs, br_rt, load_use, br_ex, br_mem, stall, squash, bubble, ops_equal;
  assign br_rs = is_beq || is_bne || is_jr;
  assign br_rt = is_beq || is_bne;

  assign load_use = ex_mem_read &&
                    ((use_rs && reg_match(ex_write_addr, rs)) ||
                     (use_rt && reg_match(ex_write_addr, rt)));
  assign br_ex    = ex_reg_write &&
                    ((br_rs && reg_match(ex_write_addr, rs)) ||
                     (br_rt && reg_match(ex_write_addr, rt)));
  assign br_mem   = mem_mem_read &&
                    ((br_rs && reg_match(mem_write_addr, rs)) ||
                     (br_rt && reg_match(mem_write_addr, rt)));
  assign stall    = load_use || br_ex || br_mem;
  assign squash   = (status != 2'b00);
  assign bubble   = squash || stall;
  assign ops_equal = (rs_fwd == rt_fwd);

  always_comb begin
    PC_IF_ID_Write = squash || !stall;
    select_PC_next = 3'b000;
    if (!bubble) begin
      if ((is_beq && ops_equal) || (is_bne && !ops_equal)) select_PC_next = 3'b100;
      else if (is_j)                                       select_PC_next = 3'b010;
      else if (is_jr)                                      select_PC_next = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bubble) begin
      id_ex_ctrl     <= '0;
      id_ex_pc_plus4 <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_shamt    <= '0;
    end else begin
      id_ex_ctrl     <= ctrl;
      id_ex_pc_plus4 <= pc4;
      id_ex_rs_data  <= rf_rs_data;
      id_ex_rt_data  <= rf_rt_data;
      id_ex_imm      <= imm_ext;
      id_ex_rs       <= rs;
      id_ex_rt       <= rt;
      id_ex_rd       <= rd;
      id_ex_shamt    <= shamt;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] IF_ID;
  logic [1:0]  status;
  logic        wb_reg_write, ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
  logic [4:0]  wb_write_addr, ex_write_addr, mem_write_addr;
  logic [31:0] wb_write_data, mem_alu_result;
  logic        PC_IF_ID_Write;
  logic [2:0]  select_PC_next;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [12:0] id_ex_ctrl;
  logic [31:0] id_ex_pc_plus4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .IF_ID(IF_ID), .status(status),
    .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_write_addr(ex_write_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_write_addr(mem_write_addr), .mem_alu_result(mem_alu_result),
    .PC_IF_ID_Write(PC_IF_ID_Write), .select_PC_next(select_PC_next),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .id_ex_ctrl(id_ex_ctrl), .id_ex_pc_plus4(id_ex_pc_plus4),
    .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_shamt(id_ex_shamt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    status = 2'b00;
    wb_reg_write = 1'b0; wb_write_addr = '0; wb_write_data = '0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_write_addr = '0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_write_addr = '0; mem_alu_result = '0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_reg_write = 1'b1; wb_write_addr = a; wb_write_data = d;
    tick();
    wb_reg_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; IF_ID = '0; clear_pipe();
    tick(); tick();
    checks++;
    if ({id_ex_ctrl, id_ex_pc_plus4, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
         id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt} !== '0) begin
      errors++; $display("FAIL reset_id_ex: ctrl %h pc4 %h imm %h", id_ex_ctrl, id_ex_pc_plus4, id_ex_imm);
    end
    checks++;
    if (PC_IF_ID_Write !== 1'b1) begin errors++; $display("FAIL reset_write: got %b want 1", PC_IF_ID_Write); end
    checks++;
    if (select_PC_next !== 3'b000) begin errors++; $display("FAIL reset_select: got %b want 000", select_PC_next); end
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    IF_ID = {32'h80000004, 32'h20080005};
    tick();
    checks++;
    if (id_ex_ctrl !== 13'h0011) begin errors++; $display("FAIL addi_ctrl: got %h want 0011", id_ex_ctrl); end
    checks++;
    if (id_ex_imm !== 32'd5) begin errors++; $display("FAIL addi_imm: got %h want 5", id_ex_imm); end
    checks++;
    if (id_ex_rt !== 5'd8) begin errors++; $display("FAIL addi_rt: got %0d want 8", id_ex_rt); end
    checks++;
    if (id_ex_pc_plus4 !== 32'h80000004) begin errors++; $display("FAIL addi_pc4: got %h want 80000004", id_ex_pc_plus4); end
  endtask

  task automatic test_decode();
    logic [31:0] instrs [8];
    logic [12:0] ctrls  [8];
    logic [31:0] imms   [8];
    instrs = '{32'h3C031234, 32'h30038000, 32'h20038000, 32'h8C030004,
               32'hAC030004, 32'h00021900, 32'h0C000001, 32'hFC000000};
    ctrls  = '{13'h1A11, 13'h0811, 13'h0011, 13'h001B, 13'h0014, 13'h1521, 13'h00C1, 13'h0000};
    imms   = '{32'h12340000, 32'h00008000, 32'hFFFF8000, 32'h00000004,
               32'h00000004, 32'h00001900, 32'h00000001, 32'h00000000};
    for (int i = 0; i < 8; i++) begin
      IF_ID = {32'h00001000, instrs[i]};
      tick();
      checks++;
      if (id_ex_ctrl !== ctrls[i]) begin
        errors++; $display("FAIL decode_ctrl[%0d]: got %h want %h", i, id_ex_ctrl, ctrls[i]);
      end
      checks++;
      if (id_ex_imm !== imms[i]) begin
        errors++; $display("FAIL decode_imm[%0d]: got %h want %h", i, id_ex_imm, imms[i]);
      end
    end
  endtask

  task automatic test_load_use();
    IF_ID = {32'h00400004, 32'h01084820};
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_addr = 5'd8;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b0) begin errors++; $display("FAIL load_use_stall: got %b want 0", PC_IF_ID_Write); end
    checks++;
    if (select_PC_next !== 3'b000) begin errors++; $display("FAIL load_use_select: got %b want 000", select_PC_next); end
    tick();
    checks++;
    if (id_ex_ctrl !== '0 || id_ex_rd !== '0 || id_ex_pc_plus4 !== '0) begin
      errors++; $display("FAIL load_use_bubble: ctrl %h rd %0d pc4 %h want 0", id_ex_ctrl, id_ex_rd, id_ex_pc_plus4);
    end
    clear_pipe();
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b1) begin errors++; $display("FAIL load_use_release: got %b want 1", PC_IF_ID_Write); end
    tick();
    checks++;
    if (id_ex_ctrl !== 13'h0021 || id_ex_rd !== 5'd9) begin
      errors++; $display("FAIL load_use_decode: ctrl %h rd %0d want 0021 9", id_ex_ctrl, id_ex_rd);
    end
    IF_ID = {32'h00400008, 32'h00004820};
    ex_mem_read = 1'b1; ex_write_addr = 5'd0;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b1) begin errors++; $display("FAIL load_use_r0: got %b want 1", PC_IF_ID_Write); end
    clear_pipe();
  endtask

  task automatic test_branch();
    IF_ID = '0;
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    IF_ID = {32'h00400010, 32'h10220003};
    #1;
    checks++;
    if (select_PC_next !== 3'b100) begin errors++; $display("FAIL beq_taken: got %b want 100", select_PC_next); end
    checks++;
    if (branch_target !== 32'h0040001C) begin errors++; $display("FAIL beq_target: got %h want 0040001C", branch_target); end
    wb_write(5'd2, 32'd8);
    #1;
    checks++;
    if (select_PC_next !== 3'b000) begin errors++; $display("FAIL beq_not_taken: got %b want 000", select_PC_next); end
    IF_ID = {32'h00400010, 32'h14220003};
    #1;
    checks++;
    if (select_PC_next !== 3'b100) begin errors++; $display("FAIL bne_taken: got %b want 100", select_PC_next); end
    IF_ID = {32'h80000004, 32'h1000FFFF};
    #1;
    checks++;
    if (select_PC_next !== 3'b100 || branch_target !== 32'h80000000) begin
      errors++; $display("FAIL beq_neg_target: sel %b tgt %h want 100 80000000", select_PC_next, branch_target);
    end
  endtask

  task automatic test_branch_hazards();
    IF_ID = {32'h00400010, 32'h10220003};
    ex_reg_write = 1'b1; ex_write_addr = 5'd1;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b0 || select_PC_next !== 3'b000) begin
      errors++; $display("FAIL br_ex_alu_stall: write %b sel %b want 0 000", PC_IF_ID_Write, select_PC_next);
    end
    tick();
    checks++;
    if (id_ex_pc_plus4 !== '0) begin errors++; $display("FAIL br_ex_alu_bubble: got %h want 0", id_ex_pc_plus4); end
    clear_pipe();
    mem_reg_write = 1'b1; mem_write_addr = 5'd1; mem_alu_result = 32'd8;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b1 || select_PC_next !== 3'b100) begin
      errors++; $display("FAIL br_mem_forward: write %b sel %b want 1 100", PC_IF_ID_Write, select_PC_next);
    end
    clear_pipe();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_addr = 5'd2;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b0) begin errors++; $display("FAIL br_load_stall1: got %b want 0", PC_IF_ID_Write); end
    tick();
    clear_pipe();
    mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_write_addr = 5'd2; mem_alu_result = 32'd7;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b0 || select_PC_next !== 3'b000) begin
      errors++; $display("FAIL br_load_stall2: write %b sel %b want 0 000", PC_IF_ID_Write, select_PC_next);
    end
    tick();
    clear_pipe();
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b1) begin errors++; $display("FAIL br_load_release: got %b want 1", PC_IF_ID_Write); end
  endtask

  task automatic test_jumps();
    IF_ID = {32'h90000008, 32'h08100040};
    #1;
    checks++;
    if (select_PC_next !== 3'b010 || jump_target !== 32'h90400100) begin
      errors++; $display("FAIL j_target: sel %b tgt %h want 010 90400100", select_PC_next, jump_target);
    end
    IF_ID = {32'h00400020, 32'h03E00008};
    mem_reg_write = 1'b1; mem_write_addr = 5'd31; mem_alu_result = 32'h00400100;
    #1;
    checks++;
    if (select_PC_next !== 3'b001 || jr_target !== 32'h00400100) begin
      errors++; $display("FAIL jr_forward: sel %b tgt %h want 001 00400100", select_PC_next, jr_target);
    end
    mem_mem_read = 1'b1;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b0 || select_PC_next !== 3'b000) begin
      errors++; $display("FAIL jr_mem_load_stall: write %b sel %b want 0 000", PC_IF_ID_Write, select_PC_next);
    end
    clear_pipe();
  endtask

  task automatic test_status();
    IF_ID = {32'h00400040, 32'h10210003};
    #1;
    checks++;
    if (select_PC_next !== 3'b100) begin errors++; $display("FAIL status_pre: got %b want 100", select_PC_next); end
    status = 2'b10;
    ex_reg_write = 1'b1; ex_write_addr = 5'd1;
    #1;
    checks++;
    if (select_PC_next !== 3'b000 || PC_IF_ID_Write !== 1'b1) begin
      errors++; $display("FAIL status_squash: sel %b write %b want 000 1", select_PC_next, PC_IF_ID_Write);
    end
    tick();
    checks++;
    if (id_ex_pc_plus4 !== '0 || id_ex_rs !== '0) begin
      errors++; $display("FAIL status_bubble: pc4 %h rs %0d want 0", id_ex_pc_plus4, id_ex_rs);
    end
    clear_pipe();
  endtask

  task automatic test_write_through();
    IF_ID = {32'h00400050, 32'h20A60001};
    wb_reg_write = 1'b1; wb_write_addr = 5'd5; wb_write_data = 32'h0000DEAD;
    tick();
    wb_reg_write = 1'b0;
    checks++;
    if (id_ex_rs_data !== 32'h0000DEAD) begin errors++; $display("FAIL write_through: got %h want 0000DEAD", id_ex_rs_data); end
  endtask

  task automatic test_reset_mid_stall();
    IF_ID = {32'h00400060, 32'h20080005};
    tick();
    IF_ID = {32'h00400064, 32'h01084820};
    ex_mem_read = 1'b1; ex_write_addr = 5'd8;
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b0) begin errors++; $display("FAIL mid_stall_pre: got %b want 0", PC_IF_ID_Write); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (id_ex_ctrl !== '0 || id_ex_pc_plus4 !== '0) begin
      errors++; $display("FAIL mid_stall_async: ctrl %h pc4 %h want 0", id_ex_ctrl, id_ex_pc_plus4);
    end
    clear_pipe();
    #1;
    rst_n = 1'b1;
    IF_ID = {32'h00400010, 32'h10220003};
    #1;
    checks++;
    if (PC_IF_ID_Write !== 1'b1 || select_PC_next !== 3'b100) begin
      errors++; $display("FAIL mid_stall_regs_cleared: write %b sel %b want 1 100", PC_IF_ID_Write, select_PC_next);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_decode();
    test_load_use();
    test_branch();
    test_branch_hazards();
    test_jumps();
    test_status();
    test_write_through();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
